// File: rtl/mem_data_pkg.sv
// mem_data_pkg
//   Shared types and constants for the mem_data_ram responder slice.
//   - word_t     : 32-bit data/address word
//   - state_t    : responder FSM encoding (IDLE / WAIT / RESP, 2 bits)
//   - MMIO_ADDR  : byte address of the debug register (used only when
//                  MEM_DATA_MMIO_EN is defined)
//   - BE_WORD    : byte-enable value for a full 32-bit store
//   - be_mask()  : expands a 4-bit byte enable into a 32-bit lane mask
package mem_data_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam word_t      MMIO_ADDR = 32'hFFFF_FFF0;
  localparam logic [3:0] BE_WORD   = 4'b1111;

  function automatic word_t be_mask(input logic [3:0] be);
    word_t m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_data_ram_if.sv
// mem_data_ram_if
//   Load/store bus between the CPU (master) and the data memory (slave).
//   Request channel : req_valid/req_ready handshake carrying we, addr,
//                     wdata and per-byte enables be.
//   Response channel: single-cycle resp_valid strobe with resp_rdata and
//                     resp_err; there is no response backpressure.
interface mem_data_ram_if;
  import mem_data_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  word_t      req_addr;
  word_t      req_wdata;
  logic [3:0] req_be;
  logic       resp_valid;
  word_t      resp_rdata;
  logic       resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_data_array.sv
// mem_data_array
//   Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enables,
//   synchronous write and registered read (read-before-write on a store).
//   Ports:
//     clk   : rising-edge clock
//     en    : access strobe; write and read register update only when set
//     we    : 1 = write the lanes selected by be
//     be    : byte enables, bit i selects wdata[8i+7:8i]
//     addr  : word index
//     wdata : write data
//     rdata : registered read data (word at addr on the last enabled edge)
//   Contents are deliberately not reset.
module mem_data_array
  import mem_data_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  word_t                 wdata,
  output word_t                 rdata
);

  word_t mem [0:(1 << ADDR_WIDTH) - 1];

  // Byte-lane writes plus a registered read port; written as a plain
  // per-lane loop so synthesis can map it onto byte-enable block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_data_ram.sv
// mem_data_ram
//   Data-memory responder for the rv32e_cpu load/store port. Accepts one
//   request at a time, waits WAIT_STATES cycles, then returns a one-cycle
//   response carrying load data or an error flag.
//
//   Parameters:
//     ADDR_WIDTH  : word-address bits (capacity 2^ADDR_WIDTH words)
//     WAIT_STATES : extra cycles between accept and response (0..15)
//     BASE_ADDR   : byte address of word 0 (4-byte aligned)
//
//   Ports:
//     clk     : rising-edge clock
//     reset   : asynchronous active-high reset
//     bus     : mem_data_ram_if.slave (request / response channels)
//     dbg_out : debug register, present only with MEM_DATA_MMIO_EN
//
//   Optional feature (macro MEM_DATA_MMIO_EN): a byte-lane-masked debug
//   register at MMIO_ADDR, written by stores and returned by loads.
//   Without the macro that address is an ordinary out-of-range error.
module mem_data_ram
  import mem_data_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input logic           clk,
  input logic           reset,
  mem_data_ram_if.slave bus
`ifdef MEM_DATA_MMIO_EN
  ,
  output word_t         dbg_out
`endif
);

  // The counter is preloaded with WAIT_STATES-1 so WAIT lasts exactly
  // WAIT_STATES cycles; with zero wait states WAIT is never entered.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            wait_cnt;

  logic                  lat_we;
  word_t                 lat_addr;
  word_t                 lat_wdata;
  logic [3:0]            lat_be;

  logic                  accept;
  logic                  commit;

  logic                  cur_we;
  word_t                 cur_addr;
  word_t                 cur_wdata;
  logic [3:0]            cur_be;

  word_t                 offset;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  is_mmio;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  logic                  array_we;
  word_t                 array_rdata;

  logic                  rsp_err_q;
  logic                  rsp_from_array_q;
`ifdef MEM_DATA_MMIO_EN
  logic                  rsp_from_mmio_q;
`endif

  assign accept = bus.req_valid && (state == IDLE) && !reset;

  // commit marks the edge that enters RESP: the store lands in the array
  // and the read port samples on this edge. With zero wait states that is
  // the accepting edge itself, which is why the request fields below are
  // taken straight from the bus while still in IDLE.
  always_comb begin
    commit = 1'b0;
    if (state == IDLE) begin
      commit = accept && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      commit = (wait_cnt == 4'd0);
    end
  end

  always_comb begin
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_we    = lat_we;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_be    = lat_be;
    end
  end

  // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap to huge
  // offsets and fall out of range. BASE_ADDR is aligned, so the low two
  // offset bits equal the low two address bits.
  assign offset       = cur_addr - BASE_ADDR;
  assign misaligned   = |offset[1:0];
  assign out_of_range = |offset[31:ADDR_WIDTH+2];
  assign word_idx     = offset[ADDR_WIDTH+1:2];

`ifdef MEM_DATA_MMIO_EN
  assign is_mmio = (cur_addr == MMIO_ADDR);
`else
  assign is_mmio = 1'b0;
`endif

  assign req_err  = !is_mmio && (misaligned || out_of_range);
  assign array_we = cur_we && !req_err && !is_mmio;

  mem_data_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (commit),
    .we   (array_we),
    .be   (cur_be),
    .addr (word_idx),
    .wdata(cur_wdata),
    .rdata(array_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and the response-kind flags captured on
  // the commit edge. Reset clears everything, so a transaction aborted in
  // WAIT never reaches its commit edge and produces no response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt         <= 4'd0;
      lat_we           <= 1'b0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      lat_be           <= 4'd0;
      rsp_err_q        <= 1'b0;
      rsp_from_array_q <= 1'b0;
`ifdef MEM_DATA_MMIO_EN
      rsp_from_mmio_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        wait_cnt  <= CNT_LOAD;
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (commit) begin
        rsp_err_q        <= req_err;
        rsp_from_array_q <= !cur_we && !req_err && !is_mmio;
`ifdef MEM_DATA_MMIO_EN
        rsp_from_mmio_q  <= !cur_we && is_mmio;
`endif
      end
    end
  end

`ifdef MEM_DATA_MMIO_EN
  // Debug register: lane-masked update on the commit edge of an MMIO store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_out <= '0;
    end else if (commit && cur_we && is_mmio) begin
      dbg_out <= (dbg_out & ~be_mask(cur_be)) | (cur_wdata & be_mask(cur_be));
    end
  end
`endif

  // Output logic. Everything is gated by state, so reset clears the
  // response immediately and rdata reads as zero for stores and errors.
  always_comb begin
    bus.req_ready  = (state == IDLE) && !reset;
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && rsp_err_q;
    bus.resp_rdata = '0;
    if (state == RESP) begin
      if (rsp_from_array_q) begin
        bus.resp_rdata = array_rdata;
      end
`ifdef MEM_DATA_MMIO_EN
      else if (rsp_from_mmio_q) begin
        bus.resp_rdata = dbg_out;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_data_ram.sv
// tb_mem_data_ram
//   Directed bench for mem_data_ram. Two instances share clock and reset:
//   dut1 with WAIT_STATES = 1 and dut0 with WAIT_STATES = 0. Stimulus
//   pushes the expected response (data, error, due cycle) into a per-DUT
//   queue; independent monitors pop and compare whenever resp_valid is
//   seen on a falling edge. Define MEM_DATA_MMIO_EN to cover the debug
//   register.
module tb_mem_data_ram;
  import mem_data_pkg::*;

  localparam int          AW   = 10;
  localparam int          WS1  = 1;
  localparam int          WS0  = 0;
  localparam logic [31:0] BASE = 32'h0001_0000;

  typedef struct {
    logic       we;
    word_t      addr;
    word_t      wdata;
    logic [3:0] be;
    word_t      exp_rdata;
    logic       exp_err;
  } vec_t;

  typedef struct {
    word_t rdata;
    logic  err;
    int    due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q1[$];
  exp_t q0[$];

  mem_data_ram_if bus1();
  mem_data_ram_if bus0();

`ifdef MEM_DATA_MMIO_EN
  word_t dbg1;
  word_t dbg0;
`endif

  mem_data_ram #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS1),
    .BASE_ADDR  (BASE)
  ) dut1 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus1)
`ifdef MEM_DATA_MMIO_EN
    ,
    .dbg_out(dbg1)
`endif
  );

  mem_data_ram #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS0),
    .BASE_ADDR  (BASE)
  ) dut0 (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus0)
`ifdef MEM_DATA_MMIO_EN
    ,
    .dbg_out(dbg0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors for the WAIT_STATES = 1 instance.
  vec_t dir_vecs [15] = '{
    '{1'b1, 32'h0001_0004, 32'hDEAD_BEEF, BE_WORD, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0001_0004, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_BEEF, 1'b0},
    '{1'b1, 32'h0001_000C, 32'h1111_1111, BE_WORD, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0001_000C, 32'h0000_AA00, 4'b0010, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0001_000C, 32'h0000_0000, BE_WORD, 32'h1111_AA11, 1'b0},
    '{1'b0, 32'h0001_0002, 32'h0000_0000, BE_WORD, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h0001_0000, 32'hCAFE_F00D, BE_WORD, 32'h0000_0000, 1'b0},
    '{1'b1, 32'h0001_1000, 32'h1234_5678, BE_WORD, 32'h0000_0000, 1'b1},
    '{1'b0, 32'h0001_0000, 32'h0000_0000, BE_WORD, 32'hCAFE_F00D, 1'b0},
    '{1'b0, 32'h0000_FFFC, 32'h0000_0000, BE_WORD, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h0001_0004, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0001_0004, 32'h0000_0000, BE_WORD, 32'hDEAD_BEEF, 1'b0},
    '{1'b1, 32'h0001_0FFC, 32'h0A0B_0C0D, BE_WORD, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0001_0FFC, 32'h0000_0000, BE_WORD, 32'h0A0B_0C0D, 1'b0},
    '{1'b1, 32'h0001_0008, 32'h55AA_55AA, BE_WORD, 32'h0000_0000, 1'b0}
  };

  // Back-to-back requests for the WAIT_STATES = 0 instance.
  vec_t b2b_vecs [3] = '{
    '{1'b1, 32'h0001_0010, 32'h0102_0304, BE_WORD, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0001_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0102_0304, 1'b0},
    '{1'b0, 32'h0001_0003, 32'h0000_0000, BE_WORD, 32'h0000_0000, 1'b1}
  };

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic driveReq(input vec_t v);
    bus1.req_valid = 1'b1;
    bus1.req_we    = v.we;
    bus1.req_addr  = v.addr;
    bus1.req_wdata = v.wdata;
    bus1.req_be    = v.be;
  endtask

  // Issues one request on dut1 and records the expected response.
  task automatic applyStimulus(input vec_t v);
    bit acc = 1'b0;
    @(negedge clk);
    driveReq(v);
    for (int n = 0; n < 20 && !acc; n++) begin
      if (bus1.req_ready) begin
        q1.push_back('{v.exp_rdata, v.exp_err, cyc + 1 + WS1});
        acc = 1'b1;
      end
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    checkOutput("ws1_accept", 32'(acc), 32'd1);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 40 && (q1.size() != 0 || q0.size() != 0); n++) begin
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("ws1_pending", 32'(q1.size()), 32'd0);
    checkOutput("ws0_pending", 32'(q0.size()), 32'd0);
  endtask

  // Scoreboard monitors: one per instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.resp_valid) begin
      if (q1.size() == 0) begin
        checkOutput("ws1_spurious_resp", 32'(bus1.resp_valid), 32'd0);
      end else begin
        e = q1.pop_front();
        checkOutput("ws1_rdata", bus1.resp_rdata, e.rdata);
        checkOutput("ws1_err", 32'(bus1.resp_err), 32'(e.err));
        checkOutput("ws1_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.resp_valid) begin
      if (q0.size() == 0) begin
        checkOutput("ws0_spurious_resp", 32'(bus0.resp_valid), 32'd0);
      end else begin
        e = q0.pop_front();
        checkOutput("ws0_rdata", bus0.resp_rdata, e.rdata);
        checkOutput("ws0_err", 32'(bus0.resp_err), 32'(e.err));
        checkOutput("ws0_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stim
    int   k;
    int   last_acc;
    logic prev_acc;
    logic acc_now;

    cyc      = 0;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_be = 4'd0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0;   bus0.req_be = 4'd0;

    // Asynchronous reset: outputs must clear before any clock edge.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_ws1_ready", 32'(bus1.req_ready), 32'd0);
    checkOutput("rst_ws1_valid", 32'(bus1.resp_valid), 32'd0);
    checkOutput("rst_ws1_err", 32'(bus1.resp_err), 32'd0);
    checkOutput("rst_ws1_rdata", bus1.resp_rdata, 32'd0);
    checkOutput("rst_ws0_ready", 32'(bus0.req_ready), 32'd0);
`ifdef MEM_DATA_MMIO_EN
    checkOutput("rst_dbg_out", dbg1, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ws1_ready", 32'(bus1.req_ready), 32'd1);
    checkOutput("post_rst_ws0_ready", 32'(bus0.req_ready), 32'd1);

    // Back-to-back on dut0: req_valid held high across three requests.
    @(negedge clk);
    k        = 0;
    last_acc = 0;
    prev_acc = 1'b0;
    bus0.req_valid = 1'b1;
    bus0.req_we    = b2b_vecs[0].we;
    bus0.req_addr  = b2b_vecs[0].addr;
    bus0.req_wdata = b2b_vecs[0].wdata;
    bus0.req_be    = b2b_vecs[0].be;
    for (int n = 0; n < 20 && k < 3; n++) begin
      checkOutput("b2b_ready", 32'(bus0.req_ready), 32'(!prev_acc));
      acc_now = bus0.req_ready;
      if (acc_now) begin
        q0.push_back('{b2b_vecs[k].exp_rdata, b2b_vecs[k].exp_err, cyc + 1 + WS0});
        if (k > 0) checkOutput("b2b_interval", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        k++;
      end
      prev_acc = acc_now;
      @(negedge clk);
      if (acc_now) begin
        if (k < 3) begin
          bus0.req_we    = b2b_vecs[k].we;
          bus0.req_addr  = b2b_vecs[k].addr;
          bus0.req_wdata = b2b_vecs[k].wdata;
          bus0.req_be    = b2b_vecs[k].be;
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
    end
    bus0.req_valid = 1'b0;
    checkOutput("b2b_accepted", 32'(k), 32'd3);
    waitDrain();

    // Directed store/load/error vectors on dut1.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(dir_vecs[i]);
    end
    waitDrain();

    // Reset during WAIT of a store: the store must be dropped silently.
    @(negedge clk);
    driveReq('{1'b1, 32'h0001_0008, 32'h0BAD_BADB, BE_WORD, 32'h0, 1'b0});
    checkOutput("abort_pre_ready", 32'(bus1.req_ready), 32'd1);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(bus1.resp_valid), 32'd0);
    checkOutput("abort_ready", 32'(bus1.req_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_post_ready", 32'(bus1.req_ready), 32'd1);
    applyStimulus('{1'b0, 32'h0001_0008, 32'h0, BE_WORD, 32'h55AA_55AA, 1'b0});
    waitDrain();

`ifdef MEM_DATA_MMIO_EN
    applyStimulus('{1'b1, MMIO_ADDR, 32'h0000_0055, 4'b0001, 32'h0, 1'b0});
    waitDrain();
    checkOutput("mmio_dbg_byte0", dbg1, 32'h0000_0055);
    applyStimulus('{1'b0, MMIO_ADDR, 32'h0, BE_WORD, 32'h0000_0055, 1'b0});
    applyStimulus('{1'b1, MMIO_ADDR, 32'hAABB_CCDD, 4'b1000, 32'h0, 1'b0});
    applyStimulus('{1'b0, MMIO_ADDR, 32'h0, BE_WORD, 32'hAA00_0055, 1'b0});
    waitDrain();
    checkOutput("mmio_dbg_byte3", dbg1, 32'hAA00_0055);
`else
    applyStimulus('{1'b1, MMIO_ADDR, 32'h0000_0055, 4'b0001, 32'h0, 1'b1});
    applyStimulus('{1'b0, MMIO_ADDR, 32'h0, BE_WORD, 32'h0, 1'b1});
    waitDrain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
